// File: rtl/pin_entry_pkg.sv
// Shared constants and FSM state type for the PIN entry collector.
package pin_entry_pkg;

  localparam logic [3:0]  KEY_CLEAR  = 4'hA;
  localparam logic [3:0]  KEY_ENTER  = 4'hB;
  localparam int unsigned MAX_DIGITS = 3;
  localparam int unsigned PIN_MAX    = 511;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SUBMIT
  } state_t;

endpackage

// File: rtl/key_debouncer.sv
// Keypad debouncer: one key_press pulse per stable press, re-armed only after a stable release.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_press,
  output logic [3:0] key
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    last_code;
  logic          armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      last_code <= '0;
      armed     <= 1'b1;
      key_press <= 1'b0;
      key       <= '0;
    end else begin
      key_press <= 1'b0;
      if (armed) begin
        if (!key_valid) begin
          cnt <= '0;
        end else if (cnt != '0 && key_code == last_code) begin
          if (cnt == LAST) begin
            key_press <= 1'b1;
            key       <= key_code;
            armed     <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          // First sample of a (possibly new) code counts as one stable sample.
          last_code <= key_code;
          if (LAST == '0) begin
            key_press <= 1'b1;
            key       <= key_code;
            armed     <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= CW'(1);
          end
        end
      end else begin
        if (key_valid) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          armed <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pin_entry_collector.sv
// Collects up to three debounced decimal digits and submits them as a 9-bit PIN.
module pin_entry_collector
  import pin_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [8:0] pin_code,
  output logic       pin_valid,
  output logic       pin_overrange,
  output logic [1:0] digit_count,
  output logic       entry_timeout,
  output logic       busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic       key_press;
  logic [3:0] key;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_press (key_press),
    .key       (key)
  );

  state_t        state, state_n;
  logic [9:0]    acc, acc_n;
  logic [1:0]    dc_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          do_submit, do_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      acc           <= '0;
      digit_count   <= '0;
      tcnt          <= '0;
      pin_code      <= '0;
      pin_valid     <= 1'b0;
      pin_overrange <= 1'b0;
      entry_timeout <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      acc           <= acc_n;
      digit_count   <= dc_n;
      tcnt          <= tcnt_n;
      pin_valid     <= do_submit;
      entry_timeout <= do_timeout;
      busy          <= (state_n != ST_IDLE);
      if (do_submit) begin
        pin_code      <= (acc > 10'(PIN_MAX)) ? 9'(PIN_MAX) : acc[8:0];
        pin_overrange <= (acc > 10'(PIN_MAX));
      end
    end
  end

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    dc_n       = digit_count;
    tcnt_n     = tcnt;
    do_submit  = 1'b0;
    do_timeout = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
      acc_n   = '0;
      dc_n    = '0;
      tcnt_n  = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_n = ST_COLLECT;
          acc_n   = '0;
          dc_n    = '0;
          tcnt_n  = '0;
        end
        ST_COLLECT: begin
          if (key_press) begin
            tcnt_n = '0;
            if (key <= 4'd9) begin
              if (digit_count < 2'(MAX_DIGITS)) begin
                acc_n = acc * 10'd10 + {6'd0, key};
                dc_n  = digit_count + 2'd1;
              end
            end else if (key == KEY_CLEAR) begin
              acc_n = '0;
              dc_n  = '0;
            end else if (key == KEY_ENTER && digit_count != '0) begin
              state_n   = ST_SUBMIT;
              do_submit = 1'b1;
            end
          end else if (digit_count != '0) begin
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
              do_timeout = 1'b1;
              acc_n      = '0;
              dc_n       = '0;
              tcnt_n     = '0;
            end else begin
              tcnt_n = tcnt + 1'b1;
            end
          end
        end
        ST_SUBMIT: begin
          state_n = ST_COLLECT;
          acc_n   = '0;
          dc_n    = '0;
          tcnt_n  = '0;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed table-driven bench for pin_entry_collector (DEBOUNCE=4, TIMEOUT=20).
module tb_pin_entry_collector;

  localparam int unsigned DB = 4;
  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst, enable, key_valid;
  logic [3:0] key_code;
  logic [8:0] pin_code;
  logic       pin_valid, pin_overrange, entry_timeout, busy;
  logic [1:0] digit_count;

  pin_entry_collector #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .pin_code      (pin_code),
    .pin_valid     (pin_valid),
    .pin_overrange (pin_overrange),
    .digit_count   (digit_count),
    .entry_timeout (entry_timeout),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int pv_pulses = 0;
  int pv_cycle = 0;
  int to_pulses = 0;
  int n_pass = 0;
  int n_total = 0;
  int last_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pin_valid) begin
      pv_pulses <= pv_pulses + 1;
      pv_cycle  <= cyc;
    end
    if (entry_timeout) to_pulses <= to_pulses + 1;
  end

  typedef struct {
    logic [3:0] code;
    int         hold;
    int         dc;
    int         pulses;
    int         pcode;
    int         ovr;
  } vec_t;

  vec_t vt [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int gap);
    key_code   = code;
    key_valid  = 1'b1;
    last_start = cyc;
    repeat (hold) tick();
    key_valid = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    int prev_pulses;
    int prev_code;

    vt[0]  = '{4'h0, 6, 1, 0, 0,   0};
    vt[1]  = '{4'h8, 6, 2, 0, 0,   0};
    vt[2]  = '{4'h7, 6, 3, 0, 0,   0};
    vt[3]  = '{4'hB, 6, 0, 1, 87,  0};
    vt[4]  = '{4'h9, 6, 1, 1, 87,  0};
    vt[5]  = '{4'h9, 6, 2, 1, 87,  0};
    vt[6]  = '{4'h9, 6, 3, 1, 87,  0};
    vt[7]  = '{4'h5, 6, 3, 1, 87,  0};
    vt[8]  = '{4'hB, 6, 0, 2, 511, 1};
    vt[9]  = '{4'h3, 2, 0, 2, 511, 1};
    vt[10] = '{4'h3, 4, 1, 2, 511, 1};
    vt[11] = '{4'hA, 6, 0, 2, 511, 1};
    vt[12] = '{4'hC, 6, 0, 2, 511, 1};
    vt[13] = '{4'hB, 6, 0, 2, 511, 1};

    rst = 1'b1; enable = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset pin_code", pin_code, 0);
    chk("reset pin_valid", pin_valid, 0);
    chk("reset overrange", pin_overrange, 0);
    chk("reset digit_count", digit_count, 0);
    chk("reset timeout", entry_timeout, 0);
    chk("reset busy", busy, 0);

    rst = 1'b0; enable = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("busy after enable", busy, 1);

    for (int i = 0; i < 14; i++) begin
      prev_pulses = pv_pulses;
      press(vt[i].code, vt[i].hold, 6);
      @(negedge clk);
      chk($sformatf("row%0d digit_count", i), digit_count, vt[i].dc);
      chk($sformatf("row%0d pin_valid pulses", i), pv_pulses, vt[i].pulses);
      chk($sformatf("row%0d pin_code", i), pin_code, vt[i].pcode);
      chk($sformatf("row%0d overrange", i), pin_overrange, vt[i].ovr);
      if (vt[i].pulses != prev_pulses)
        chk($sformatf("row%0d submit latency", i), pv_cycle - last_start, DB + 1);
    end
    chk("no timeout so far", to_pulses, 0);

    // Timeout of a partial entry, then a fresh entry.
    press(4'h4, 6, 0);
    repeat (30) tick();
    @(negedge clk);
    chk("timeout pulses", to_pulses, 1);
    chk("timeout digit_count", digit_count, 0);
    chk("timeout busy", busy, 1);
    press(4'h1, 6, 6);
    press(4'h2, 6, 6);
    press(4'hB, 6, 6);
    @(negedge clk);
    chk("post-timeout pin_code", pin_code, 12);
    chk("post-timeout pulses", pv_pulses, 3);
    chk("post-timeout overrange", pin_overrange, 0);

    // Enable drop coincident with the enter key_press.
    press(4'h5, 6, 6);
    press(4'h5, 6, 6);
    @(negedge clk);
    chk("pre-drop digit_count", digit_count, 2);
    prev_pulses = pv_pulses;
    prev_code   = pin_code;
    key_code  = 4'hB;
    key_valid = 1'b1;
    repeat (DB) tick();
    enable = 1'b0;
    tick();
    @(negedge clk);
    chk("drop busy", busy, 0);
    chk("drop digit_count", digit_count, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("drop no pin_valid", pv_pulses, prev_pulses);
    chk("drop pin_code held", pin_code, prev_code);
    key_valid = 1'b0;
    repeat (6) tick();
    enable = 1'b1;
    tick(); tick();

    // Reset in the middle of an entry.
    press(4'h7, 6, 6);
    @(negedge clk);
    chk("pre-reset digit_count", digit_count, 1);
    prev_pulses = pv_pulses;
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid reset pin_code", pin_code, 0);
    chk("mid reset digit_count", digit_count, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset overrange", pin_overrange, 0);
    chk("mid reset timeout", entry_timeout, 0);
    repeat (4) tick();
    @(negedge clk);
    chk("no pin_valid after reset", pv_pulses, prev_pulses);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pin_entry_collector.md
PIN_ENTRY_COLLECTOR -- requirements
Module: pin_entry_collector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples needed to accept a key press or a key release.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: idle cycles after the last accepted key before a partial entry is discarded.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  entry window open; high while the downstream parking controller awaits a PIN.
REQ-006 key_valid  input  1  raw keypad strobe, undebounced.
REQ-007 key_code  input  4  raw key: 0-9 digit, 4'hA clear, 4'hB enter, 4'hC-4'hF ignored.
REQ-008 pin_code  output  9  last submitted PIN, binary; feeds the controller's 9-bit attempt input.
REQ-009 pin_valid  output  1  one-cycle pulse; pin_code is valid on this cycle.
REQ-010 pin_overrange  output  1  high with pin_valid when the entered decimal value exceeds 511.
REQ-011 digit_count  output  2  digits currently buffered, 0-3.
REQ-012 entry_timeout  output  1  one-cycle pulse when a partial entry is discarded by timeout.
REQ-013 busy  output  1  high when not in IDLE.

Function
REQ-014 Debounce: key_press is a one-cycle internal pulse, asserted when key_valid=1 with an unchanged key_code for DEBOUNCE_CYCLES consecutive samples.
REQ-015 After key_press, no further press is accepted until key_valid=0 for DEBOUNCE_CYCLES consecutive samples.
REQ-016 A key_code change while key_valid is high restarts the stability count.
REQ-017 FSM states are IDLE, COLLECT and SUBMIT.
REQ-018 IDLE: accumulator=0, digit_count=0; enable=1 moves to COLLECT on the next edge.
REQ-019 COLLECT, digit key with digit_count<3: accumulator = accumulator*10 + digit (10-bit internal); digit_count increments.
REQ-020 COLLECT, digit key with digit_count=3: key ignored, no state change.
REQ-021 COLLECT, clear key: accumulator=0, digit_count=0.
REQ-022 COLLECT, enter key with digit_count>=1: moves to SUBMIT.
REQ-023 COLLECT, enter key with digit_count=0, or any code 4'hC-4'hF: key ignored.
REQ-024 SUBMIT lasts one cycle: pin_valid=1 on the cycle after the enter key_press.
REQ-025 In SUBMIT, pin_code = min(accumulator, 511) and pin_overrange = (accumulator>511); the accumulator then clears and the FSM returns to COLLECT.
REQ-026 pin_code and pin_overrange hold their values until the next SUBMIT.
REQ-027 Timeout counter: cleared on every accepted key; counts only in COLLECT with digit_count>=1.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES: entry_timeout pulses once, the accumulator and digit_count clear, and the FSM stays in COLLECT.
REQ-029 enable=0 in any state forces IDLE on the next edge with the buffer cleared; this takes priority over a simultaneous enter, digit or timeout, and no pin_valid is issued.
REQ-030 enable=0 does not reset the debouncer; a key held across an enable rise must be released before the next press is accepted.
REQ-031 All outputs are registered; no combinational path runs from any input to any output.

Reset
REQ-032 On rst: FSM=IDLE, accumulator=0, digit_count=0, timeout counter=0, debouncer counters=0.
REQ-033 On rst: pin_code=0, pin_valid=0, pin_overrange=0, entry_timeout=0, busy=0.
REQ-034 rst asserted mid-entry or during SUBMIT discards the entry; no pin_valid is emitted on or after the reset edge.

Structure
REQ-035 Shared package pin_entry_pkg holds KEY_CLEAR=4'hA, KEY_ENTER=4'hB, MAX_DIGITS=3, PIN_MAX=511 and the FSM state encoding.
REQ-036 Sub-module key_debouncer (inputs key_valid and key_code; outputs key_press and the 4-bit key value) implements REQ-014 to REQ-016; the top module contains the FSM, accumulator and timeout logic.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-037 enable=1; press 0, 8, 7, then enter, each held 6 cycles with 6-cycle gaps -> pin_valid pulse of one cycle, one cycle after the enter key_press; pin_code=87; pin_overrange=0.
REQ-038 Press 9, 9, 9, then enter -> pin_code=511 and pin_overrange=1; a fourth digit 5 before enter is ignored and digit_count stays 3.
REQ-039 A 2-cycle key_valid glitch with code 3 -> no digit accepted, digit_count stays 0; a 4-cycle hold -> digit_count=1.
REQ-040 Press 4, then no key for 20 cycles -> one entry_timeout pulse and digit_count=0; a subsequent 1, 2, enter -> pin_code=12.
REQ-041 Press 5, 5; drop enable in the same cycle as the enter key_press -> no pin_valid, busy=0 on the next cycle, pin_code still holds its prior value.
REQ-042 Assert rst for 1 cycle during digit entry -> all outputs 0 on the next cycle and state IDLE.
